cke_multi_generator: RTL and testbench
======================================

CKE_MULTI_GENERATOR -- requirements
Module: cke_multi_generator

Interface
REQ-001 The block SHALL take parameter pChannels, default 4, the number of independent clock-enable channels (1..16).
REQ-002 The block SHALL take parameter pDivWidth, default 16, the prescale compare width per channel.
REQ-003 The block SHALL take parameter pPostWidth, default 8, the post-divider compare width per channel.
REQ-004 The block SHALL have port iSysClk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port iSysRst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port iDiv, input, pChannels*pDivWidth bits: per-channel prescale terminal value; channel n uses bits [n*pDivWidth +: pDivWidth].
REQ-007 The block SHALL have port iPost, input, pChannels*pPostWidth bits: per-channel post-divider terminal value, packed the same way as iDiv.
REQ-008 The block SHALL have port iEn, input, pChannels bits: per-channel run enable.
REQ-009 The block SHALL have port iOneShot, input, pChannels bits: per-channel mode; 0 = periodic, 1 = single pulse.
REQ-010 The block SHALL have port iSync, input, 1 bit: a synchronous restart of all channels.
REQ-011 The block SHALL have port oCke, output, pChannels bits: per-channel one-cycle enable pulse.
REQ-012 The block SHALL have port oSq, output, pChannels bits: per-channel square wave that toggles on every pulse.
REQ-013 The block SHALL have port oDone, output, pChannels bits: per-channel flag meaning the one-shot pulse has been issued.

Function
REQ-014 Each channel SHALL keep a prescale counter DC (pDivWidth bits) and a post counter PC (pPostWidth bits).
REQ-015 Each channel SHALL have the states IDLE, RUN and HALT.
- IDLE -> RUN when iEn = 1.
- RUN -> IDLE when iEn = 0.
- RUN -> HALT after the one-shot pulse.
- HALT -> IDLE when iEn = 0.
REQ-016 In IDLE and HALT, DC and PC SHALL be held at 0 and oCke SHALL be 0.
REQ-017 In RUN, a tick SHALL occur when DC >= iDiv[n]; on a tick DC <= 0, otherwise DC <= DC + 1. The >= compare means a divisor lowered mid-count never wraps.
REQ-018 On a tick, if PC >= iPost[n], PC SHALL be set to 0 and a terminal event SHALL occur; otherwise PC <= PC + 1.
REQ-019 oCke[n] SHALL be registered and high for exactly one cycle, in the cycle after a terminal event.
REQ-020 The pulse period SHALL be P = (iDiv+1)*(iPost+1) cycles.
REQ-021 The first pulse SHALL appear P cycles after the first RUN cycle.
REQ-022 When iDiv = 0 and iPost = 0, oCke SHALL be continuously high while in RUN, starting 1 cycle after entry.
REQ-023 oSq[n] SHALL toggle in the same cycle that oCke[n] rises, giving period 2P; it SHALL hold its value through IDLE and HALT.
REQ-024 With iOneShot[n] = 1, the terminal event SHALL move the channel to HALT and set oDone[n] = 1 together with the single oCke pulse.
REQ-025 oDone SHALL clear on leaving HALT or on iSync.
REQ-026 A change of iOneShot during RUN SHALL take effect at the next terminal event.
REQ-027 iSync = 1 SHALL, in one cycle, clear DC, PC, oCke, oSq and oDone of every channel and return any HALT channel to IDLE.
REQ-028 Channels with iEn = 1 SHALL restart so their first post-sync pulse is P cycles after iSync falls, keeping all channels phase-aligned.
REQ-029 iSync SHALL have priority over a coincident terminal event; no pulse and no toggle occur that cycle.
REQ-030 Channels SHALL be fully independent except for iSync and reset.
REQ-031 iDiv and iPost SHALL be sampled live every cycle and need no handshake.
REQ-032 The block SHALL use no latches and no internal clock derivation; oCke is an enable only.

Reset
REQ-033 While iSysRst = 1, all channels SHALL be in IDLE with DC = 0, PC = 0, oCke = 0, oSq = 0 and oDone = 0.
REQ-034 Reset SHALL take priority over iSync and iEn.
REQ-035 A reset asserted mid-count SHALL take effect at the next edge with no residual pulse.

Verification
REQ-036 Periodic case: ch0 iDiv = 4, iPost = 2, iEn = 1 from reset release -> oCke pulses at cycles 15, 30, 45; oSq toggles at 15 and 30.
REQ-037 Full-rate case: iDiv = 0, iPost = 0, iEn = 1 -> oCke = 1 on every cycle from cycle 1; oSq toggles every cycle.
REQ-038 One-shot case: iOneShot = 1, iDiv = 9, iPost = 0 -> a single pulse at cycle 10 with oDone = 1; no further pulses; dropping iEn clears oDone.
REQ-039 Live lowering: iDiv changed from 100 to 3 while DC = 50 -> a tick on the next cycle, then the period becomes 4*(iPost+1) with no wrap-around.
REQ-040 Sync alignment: ch0 P = 6 and ch1 P = 8 free-running, iSync pulsed at an arbitrary cycle, including one coinciding with a ch0 terminal event -> no pulse that cycle; all oSq = 0; the next pulses are 6 and 8 cycles after iSync falls.
REQ-041 Reset mid-operation: iSysRst pulsed for 1 cycle one cycle before an expected pulse -> no pulse; all outputs are 0 the cycle after; counting restarts from 0.

Source files
------------

// File: rtl/cke_multi_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : cke_multi_generator_if
// Description : Bundle of per-channel control inputs and clock-enable outputs
//               shared between the clock-enable generator and its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface cke_multi_generator_if #(
  parameter int pChannels  = 4,
  parameter int pDivWidth  = 16,
  parameter int pPostWidth = 8
);
  logic [pChannels*pDivWidth-1:0]  iDiv;
  logic [pChannels*pPostWidth-1:0] iPost;
  logic [pChannels-1:0]            iEn;
  logic [pChannels-1:0]            iOneShot;
  logic                            iSync;
  logic [pChannels-1:0]            oCke;
  logic [pChannels-1:0]            oSq;
  logic [pChannels-1:0]            oDone;

  // User side: drives the controls, observes the enables.
  modport master (
    output iDiv, iPost, iEn, iOneShot, iSync,
    input  oCke, oSq, oDone
  );

  // Generator side.
  modport slave (
    input  iDiv, iPost, iEn, iOneShot, iSync,
    output oCke, oSq, oDone
  );
endinterface
`default_nettype wire

// File: rtl/cke_multi_generator.sv
`default_nettype none
// ============================================================================
// Module      : cke_multi_generator
// Description : pChannels independent clock-enable generators. Each channel
//               runs a prescale counter and a post counter; every
//               (iDiv+1)*(iPost+1) RUN cycles it emits a one-cycle enable,
//               toggles a square wave and, in one-shot mode, halts.
// Revision    : 1.0 - initial release
// ============================================================================
module cke_multi_generator #(
  parameter int pChannels  = 4,
  parameter int pDivWidth  = 16,
  parameter int pPostWidth = 8
) (
  input  logic                  iSysClk,
  input  logic                  iSysRst,
  cke_multi_generator_if.slave  io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  logic [pChannels-1:0] w_cke;
  logic [pChannels-1:0] w_sq;
  logic [pChannels-1:0] w_done;

  for (genvar n = 0; n < pChannels; n++) begin : g_chan
    state_t                r_state;
    logic [pDivWidth-1:0]  r_dc;
    logic [pPostWidth-1:0] r_pc;
    logic                  r_cke;
    logic                  r_sq;
    logic                  r_done;
    logic [pDivWidth-1:0]  w_div;
    logic [pPostWidth-1:0] w_post;
    logic                  w_tick;
    logic                  w_term;

    // Terminal values are taken live each cycle; >= lets a lowered divisor
    // end the current count immediately instead of wrapping.
    assign w_div  = io_bus.iDiv[n*pDivWidth +: pDivWidth];
    assign w_post = io_bus.iPost[n*pPostWidth +: pPostWidth];
    assign w_tick = (r_state == ST_RUN) && io_bus.iEn[n] && (r_dc >= w_div);
    assign w_term = w_tick && (r_pc >= w_post);

    // Channel state machine, counters and registered outputs.
    always_ff @(posedge iSysClk) begin
      if (iSysRst) begin
        r_state <= ST_IDLE;
        r_dc    <= '0;
        r_pc    <= '0;
        r_cke   <= 1'b0;
        r_sq    <= 1'b0;
        r_done  <= 1'b0;
      end else if (io_bus.iSync) begin
        // Restart: enabled channels re-enter RUN with cleared counters so
        // every channel's next pulse is one full period after the sync.
        r_dc    <= '0;
        r_pc    <= '0;
        r_cke   <= 1'b0;
        r_sq    <= 1'b0;
        r_done  <= 1'b0;
        r_state <= ((r_state != ST_HALT) && io_bus.iEn[n]) ? ST_RUN : ST_IDLE;
      end else begin
        r_cke <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            r_dc <= '0;
            r_pc <= '0;
            if (io_bus.iEn[n]) begin
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (!io_bus.iEn[n]) begin
              r_state <= ST_IDLE;
              r_dc    <= '0;
              r_pc    <= '0;
            end else begin
              if (w_tick) begin
                r_dc <= '0;
                r_pc <= w_term ? '0 : r_pc + 1'b1;
              end else begin
                r_dc <= r_dc + 1'b1;
              end
              if (w_term) begin
                r_cke <= 1'b1;
                r_sq  <= ~r_sq;
                // Mode is looked at only here, so a change mid-run applies
                // from the next terminal event onwards.
                if (io_bus.iOneShot[n]) begin
                  r_state <= ST_HALT;
                  r_done  <= 1'b1;
                end
              end
            end
          end
          ST_HALT: begin
            r_dc <= '0;
            r_pc <= '0;
            if (!io_bus.iEn[n]) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_dc    <= '0;
            r_pc    <= '0;
          end
        endcase
      end
    end

    assign w_cke[n]  = r_cke;
    assign w_sq[n]   = r_sq;
    assign w_done[n] = r_done;
  end

  assign io_bus.oCke  = w_cke;
  assign io_bus.oSq   = w_sq;
  assign io_bus.oDone = w_done;

endmodule
`default_nettype wire

// File: tb/tb_cke_multi_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cke_multi_generator
// Description : Self-checking bench: reset checks, a vector table on channel
//               0, hand-written timing sequences and a randomized run against
//               a period-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cke_multi_generator;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int PW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cke_multi_generator_if #(.pChannels(NCH), .pDivWidth(DW), .pPostWidth(PW)) bus ();

  cke_multi_generator #(.pChannels(NCH), .pDivWidth(DW), .pPostWidth(PW)) dut (
    .iSysClk (clk),
    .iSysRst (rst),
    .io_bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state 0 idle, 1 run, 2 halt; age = RUN cycles since start.
  int m_st[NCH];
  int m_age[NCH];
  bit m_cke[NCH];
  bit m_sq[NCH];
  bit m_done[NCH];

  typedef struct {
    bit en; bit os; bit sy; int dv; int ps;
    bit ecke; bit esq; bit edone;
  } vec_t;
  vec_t tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_ch(input int n, input int dv, input int ps);
    bus.iDiv[n*DW +: DW]  = DW'(dv);
    bus.iPost[n*PW +: PW] = PW'(ps);
  endtask

  function automatic int period(input int n);
    return (int'(bus.iDiv[n*DW +: DW]) + 1) * (int'(bus.iPost[n*PW +: PW]) + 1);
  endfunction

  task automatic model_clear();
    for (int n = 0; n < NCH; n++) begin
      m_st[n] = 0; m_age[n] = 0; m_cke[n] = 0; m_sq[n] = 0; m_done[n] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    for (int n = 0; n < NCH; n++) begin
      int p;
      p = period(n);
      if (rst) begin
        m_st[n] = 0; m_age[n] = 0; m_cke[n] = 0; m_sq[n] = 0; m_done[n] = 0;
      end else if (bus.iSync) begin
        m_cke[n] = 0; m_sq[n] = 0; m_done[n] = 0; m_age[n] = 0;
        m_st[n] = (m_st[n] != 2 && bus.iEn[n]) ? 1 : 0;
      end else begin
        m_cke[n] = 0;
        case (m_st[n])
          0: if (bus.iEn[n]) begin m_st[n] = 1; m_age[n] = 0; end
          1: begin
            if (!bus.iEn[n]) m_st[n] = 0;
            else begin
              if ((m_age[n] + 1) % p == 0) begin
                m_cke[n] = 1;
                m_sq[n]  = ~m_sq[n];
                if (bus.iOneShot[n]) begin m_st[n] = 2; m_done[n] = 1; end
              end
              m_age[n]++;
            end
          end
          default: if (!bus.iEn[n]) begin m_st[n] = 0; m_done[n] = 0; end
        endcase
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.iDiv = '0; bus.iPost = '0; bus.iEn = '0; bus.iOneShot = '0; bus.iSync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cke",  bus.oCke,  0);
    chk("reset_sq",   bus.oSq,   0);
    chk("reset_done", bus.oDone, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Enable the given channels and step through the edge that enters RUN.
  task automatic start(input logic [NCH-1:0] en);
    @(negedge clk);
    bus.iEn = en;
    @(posedge clk);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl = '{
      '{1,0,0,0,0, 0,0,0}, '{1,0,0,0,0, 1,1,0}, '{1,0,0,0,0, 1,0,0},
      '{1,0,0,0,0, 1,1,0}, '{0,0,0,0,0, 0,1,0}, '{0,0,0,1,0, 0,1,0},
      '{1,0,0,1,0, 0,1,0}, '{1,0,0,1,0, 0,1,0}, '{1,0,0,1,0, 1,0,0},
      '{1,0,0,1,0, 0,0,0}, '{1,0,1,1,0, 0,0,0}, '{1,0,0,1,0, 0,0,0},
      '{1,0,0,1,0, 1,1,0}, '{0,1,0,0,0, 0,1,0}, '{1,1,0,0,0, 0,1,0},
      '{1,1,0,0,0, 1,0,1}, '{1,1,0,0,0, 0,0,1}, '{1,1,1,0,0, 0,0,0},
      '{1,1,0,0,0, 0,0,0}, '{1,1,0,0,0, 1,1,1}, '{0,1,0,0,0, 0,1,0}
    };

    // Vector table on channel 0: full rate, enable drop, sync over a
    // terminal event, one-shot halt and sync out of HALT.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      bus.iEn[0] = tbl[i].en; bus.iOneShot[0] = tbl[i].os; bus.iSync = tbl[i].sy;
      set_ch(0, tbl[i].dv, tbl[i].ps);
      cyc();
      chk($sformatf("tbl%0d_cke", i),  bus.oCke[0],  tbl[i].ecke);
      chk($sformatf("tbl%0d_sq", i),   bus.oSq[0],   tbl[i].esq);
      chk($sformatf("tbl%0d_done", i), bus.oDone[0], tbl[i].edone);
    end

    // Periodic: P = 15, pulses at 15/30/45, square wave toggles with them.
    do_reset();
    set_ch(0, 4, 2);
    start(4'b0001);
    for (int c = 1; c <= 46; c++) begin
      cyc();
      chk("periodic_cke", bus.oCke[0], (c % 15 == 0));
      chk("periodic_sq",  bus.oSq[0],  (c / 15) % 2);
    end

    // One-shot: single pulse at 10 with done, then silence; en drop clears done.
    do_reset();
    set_ch(0, 9, 0);
    bus.iOneShot[0] = 1'b1;
    start(4'b0001);
    for (int c = 1; c <= 30; c++) begin
      cyc();
      chk("oneshot_cke",  bus.oCke[0],  (c == 10));
      chk("oneshot_done", bus.oDone[0], (c >= 10));
    end
    @(negedge clk);
    bus.iEn[0] = 1'b0;
    cyc();
    chk("oneshot_done_clear", bus.oDone[0], 0);

    // Live lowering of the divisor from 100 to 3 while DC = 50.
    do_reset();
    set_ch(0, 100, 0);
    start(4'b0001);
    for (int c = 1; c <= 50; c++) begin
      cyc();
      chk("lower_pre_cke", bus.oCke[0], 0);
    end
    @(negedge clk);
    set_ch(0, 3, 0);
    for (int c = 51; c <= 60; c++) begin
      cyc();
      chk("lower_post_cke", bus.oCke[0], (c == 51 || c == 55 || c == 59));
    end

    // Sync alignment: ch0 P=6, ch1 P=8, sync on a ch0 terminal event (cycle 23).
    do_reset();
    set_ch(0, 2, 1);
    set_ch(1, 3, 1);
    start(4'b0011);
    for (int c = 1; c <= 23; c++) begin
      cyc();
      chk("align_pre_cke0", bus.oCke[0], (c % 6 == 0));
      chk("align_pre_cke1", bus.oCke[1], (c % 8 == 0));
    end
    chk("align_pre_sq0", bus.oSq[0], 1);
    @(negedge clk);
    bus.iSync = 1'b1;
    cyc();
    chk("align_sync_cke", bus.oCke, 0);
    chk("align_sync_sq",  bus.oSq,  0);
    @(negedge clk);
    bus.iSync = 1'b0;
    for (int c = 25; c <= 34; c++) begin
      cyc();
      chk("align_post_cke0", bus.oCke[0], (c == 30));
      chk("align_post_cke1", bus.oCke[1], (c == 32));
    end

    // Reset one cycle before the second expected pulse of a P=6 channel.
    do_reset();
    set_ch(0, 2, 1);
    start(4'b0001);
    for (int c = 1; c <= 11; c++) begin
      cyc();
      chk("rstmid_pre_cke", bus.oCke[0], (c == 6));
    end
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("rstmid_cke",  bus.oCke,  0);
    chk("rstmid_sq",   bus.oSq,   0);
    chk("rstmid_done", bus.oDone, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      cyc();
      chk("rstmid_post_cke", bus.oCke[0], (c == 6));
    end

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < NCH; n++) set_ch(n, $urandom_range(0, 3), $urandom_range(0, 3));
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 599) == 0);
      bus.iSync = ($urandom_range(0, 79) == 0);
      for (int n = 0; n < NCH; n++) begin
        if ($urandom_range(0, 19) == 0) bus.iEn[n] = ~bus.iEn[n];
        if ($urandom_range(0, 29) == 0) bus.iOneShot[n] = ~bus.iOneShot[n];
        if (m_st[n] != 1 && $urandom_range(0, 3) == 0)
          set_ch(n, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      @(posedge clk);
      model_step();
      #1;
      for (int n = 0; n < NCH; n++) begin
        chk($sformatf("rand_cke%0d", n),  bus.oCke[n],  m_cke[n]);
        chk($sformatf("rand_sq%0d", n),   bus.oSq[n],   m_sq[n]);
        chk($sformatf("rand_done%0d", n), bus.oDone[n], m_done[n]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
